// File: rtl/data_mem_responder_pkg.sv
// mem_pkg: shared funct3 codes, responder state encoding and alignment helper
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, RD, RESP} rsp_state_e;
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return (funct3[1:0] == 2'b01 && offset[0]) || (funct3[1:0] == 2'b10 && offset != 2'b00);
  endfunction
endpackage

// File: rtl/data_mem_responder_lane_align.sv
// mem_lane_align: byte-lane load extract/extend and sub-word store merge
// i_funct3/i_offset select the lane; i_rdata is the SRAM word, i_wdata the
// right-aligned store data; o_load is the extended load, o_merge the merged word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);
  logic [4:0]  w_sh;
  logic [31:0] w_lane;
  logic [31:0] w_mask;
  assign w_sh   = {i_offset, 3'b000};
  assign w_lane = i_rdata >> w_sh;
  assign w_mask = (i_funct3[1:0] == 2'b00 ? 32'h0000_00FF :
                   i_funct3[1:0] == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << w_sh;
  assign o_merge = (i_rdata & ~w_mask) | ((i_wdata << w_sh) & w_mask);
  always_comb begin
    o_load = i_funct3 == F3_B  ? {{24{w_lane[7]}}, w_lane[7:0]} :
             i_funct3 == F3_BU ? {24'h0, w_lane[7:0]} :
             i_funct3 == F3_H  ? {{16{w_lane[15]}}, w_lane[15:0]} :
             i_funct3 == F3_HU ? {16'h0, w_lane[15:0]} : i_rdata;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store responder over a synchronous-read word SRAM
// Request channel req_*, response channel rsp_*, SRAM port sram_*.
// Sub-word stores become read (accept cycle) + merged write (RD cycle).
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [AW-1:0]     sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
  rsp_state_e  r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [AW-1:0] r_addr;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_bad_f3, w_oob, w_err, w_acc, w_sw, w_rmw;
  logic [31:0] w_load, w_merge;
  assign w_bad_f3 = req_we ? (req_funct3 > F3_W)
                           : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign w_oob    = (req_addr >> 2) >= ADDR_W'(DEPTH_WORDS);
  assign w_err    = w_bad_f3 || w_oob || is_misaligned(req_funct3, req_addr[1:0]);
  assign w_acc    = r_state == IDLE && req_valid && !w_err;
  assign w_sw     = w_acc && req_we && req_funct3 == F3_W;
  assign w_rmw    = r_state == RD && r_we;
  assign req_ready  = r_state == IDLE;
  assign rsp_valid  = r_state == RESP;
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign sram_en    = w_acc || w_rmw;
  assign sram_we    = w_sw || w_rmw;
  assign sram_addr  = w_acc ? req_addr[AW+1:2] : w_rmw ? r_addr : '0;
  assign sram_wdata = w_sw ? req_wdata : w_rmw ? w_merge : '0;
  mem_lane_align u_align (
    .i_funct3 (r_funct3),
    .i_offset (r_offset),
    .i_rdata  (sram_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_funct3 <= '0;
      r_offset <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_funct3 <= req_funct3;
          r_offset <= req_addr[1:0];
          r_wdata  <= req_wdata;
          r_we     <= req_we;
          r_addr   <= req_addr[AW+1:2];
          r_rdata  <= '0;
          r_err    <= w_err;
          r_state  <= (w_err || w_sw) ? RESP : RD;
        end
        RD: begin
          r_rdata <= r_we ? 32'h0 : w_load;
          r_state <= RESP;
        end
        default: if (rsp_ready) r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed + random checks against a byte-array memory model
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata = '0;
  logic [31:0] mem [DEPTH];
  logic [7:0]  ref_b [4*DEPTH];
  int          errors = 0, checks = 0, en_cnt = 0;

  data_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      en_cnt <= en_cnt + 1;
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << f3[1:0];
    if (a >= 32'(4 * DEPTH)) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input string tag);
    bit          e;
    int          lat, en0, n;
    logic [31:0] exp_d;
    e     = ref_err(we, f3, a);
    exp_d = (e || we) ? 32'h0 : ref_load(f3, a);
    en0   = en_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'($urandom_range(0, 1));
    chk({tag, "_ready_in"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), (e || (we && f3 == 3'd2)) ? 32'd1 : 32'd2);
    chk({tag, "_rdata"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(e));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {rsp_valid, req_ready, rsp_err, rsp_rdata[28:0]},
          {1'b1, 1'b0, e, exp_d[28:0]});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_ready_out"}, {30'h0, req_ready, rsp_valid}, 32'b10);
    if (e) chk({tag, "_no_sram"}, 32'(en_cnt - en0), 32'd0);
    if (!e && we) begin
      n = 1 << f3[1:0];
      for (int i = 0; i < n; i++) ref_b[a + i] = wd[8 * i +: 8];
    end
  endtask

  initial begin
    int bad;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < 4 * DEPTH; i++) ref_b[i] = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {req_ready, rsp_valid, rsp_err, sram_en, sram_we, 27'h0},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'h0});
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_rsp_ready_noeffect", {31'h0, rsp_valid}, 32'h0);
    rsp_ready = 1'b0;

    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "sw10");
    do_req(0, 3'd2, 32'h10, 32'h0, 0, "lw10");
    do_req(1, 3'd2, 32'h20, 32'h11223344, 0, "sw20");
    do_req(1, 3'd0, 32'h23, 32'h000000A5, 0, "sb23");
    chk("sb23_word", mem[8], 32'hA5223344);
    do_req(0, 3'd0, 32'h23, 32'h0, 0, "lb23");
    do_req(0, 3'd4, 32'h23, 32'h0, 0, "lbu23");
    do_req(0, 3'd0, 32'h20, 32'h0, 0, "lb20");
    do_req(1, 3'd2, 32'h20, 32'h11223344, 0, "sw20b");
    do_req(1, 3'd1, 32'h22, 32'h00008001, 0, "sh22");
    chk("sh22_word", mem[8], 32'h80013344);
    do_req(0, 3'd1, 32'h22, 32'h0, 0, "lh22");
    do_req(0, 3'd5, 32'h22, 32'h0, 0, "lhu22");
    do_req(0, 3'd2, 32'h06, 32'h0, 0, "err_lw06");
    do_req(1, 3'd1, 32'h11, 32'hFFFF, 0, "err_sh11");
    do_req(0, 3'd3, 32'h40, 32'h0, 0, "err_f3_011");
    do_req(1, 3'd4, 32'h40, 32'h12, 0, "err_st_f3");
    do_req(0, 3'd2, 32'(4 * DEPTH), 32'h0, 0, "err_oob");
    do_req(0, 3'd2, 32'h20, 32'h0, 5, "lw_bp");

    do_req(1, 3'd2, 32'h30, 32'h0, 0, "sw30");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h30; req_wdata = 32'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("sb30_rd_write", {30'h0, sram_en, sram_we}, 32'b11);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {req_ready, rsp_valid, rsp_err, sram_en, sram_we, 27'h0},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 27'h0});
    chk("midrst_rdata", rsp_rdata, 32'h0);
    chk("midrst_sram", {sram_wdata[21:0], sram_addr}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_mem", mem[12], 32'h0);
    do_req(0, 3'd2, 32'h30, 32'h0, 0, "lw30");

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 255))
                                      : 32'($urandom_range(0, 255));
      do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 2), "rnd");
    end

    bad = 0;
    for (int w = 0; w < 128; w++)
      if (mem[w] !== {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]}) bad++;
    chk("mem_sweep", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
